// File: rtl/secure_store.sv
// secure_store: keyed register-file store for encoded words from the security block.
// Every write and read must present the access key. Consecutive bad-key accesses
// are counted; reaching MAX_FAIL locks the store for LOCK_CYCLES cycles, during
// which writes are back-pressured and reads are answered with an error pulse.
module secure_store #(
    parameter int          DEPTH       = 8,
    parameter int          ADDR_W      = 3,
    parameter logic [15:0] KEY         = 16'h0032,
    parameter int          MAX_FAIL    = 3,
    parameter int          LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [15:0]       wr_key,
    output logic              wr_err,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_key,
    output logic              rd_data_valid,
    output logic [31:0]       rd_data,
    output logic              rd_err,
    output logic              locked,
    output logic [2:0]        fail_count
);

    // The lock counter only ever holds LOCK_CYCLES-1 down to 0.
    localparam int              CNT_W     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [2:0]      MAX_FAIL3 = 3'(MAX_FAIL);
    localparam logic [3:0]      MAX_FAIL4 = 4'(MAX_FAIL);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [2:0]         fail_next;
    logic [CNT_W-1:0]   lock_cnt;
    logic [CNT_W-1:0]   lock_cnt_next;

    logic [31:0]        mem [DEPTH];

    logic               wr_fire;
    logic               wr_good;
    logic               wr_bad;
    logic               rd_good;
    logic               rd_bad;
    logic               rd_blocked;
    logic               any_good;
    logic [1:0]         failures;
    logic [3:0]         fail_sum;

    // Classify this cycle's accesses; reads while locked are refused but not counted.
    always_comb begin
        wr_fire    = wr_valid && wr_ready;
        wr_good    = wr_fire && (wr_key == KEY);
        wr_bad     = wr_fire && (wr_key != KEY);
        rd_good    = rd_valid && !locked && (rd_key == KEY);
        rd_bad     = rd_valid && !locked && (rd_key != KEY);
        rd_blocked = rd_valid && locked;
        any_good   = wr_good || rd_good;
        failures   = {1'b0, wr_bad} + {1'b0, rd_bad};
        fail_sum   = {1'b0, fail_count} + {2'b00, failures};
    end

    // FSM outputs depend only on the state so they change on the state edge.
    always_comb begin
        locked   = (state == ST_LOCKED);
        wr_ready = (state != ST_LOCKED);
    end

    // Next-state logic: saturating failure count, lock entry and timed lock exit.
    always_comb begin
        state_next    = state;
        fail_next     = fail_count;
        lock_cnt_next = lock_cnt;
        case (state)
            ST_OPEN: begin
                if (failures != 2'd0) begin
                    fail_next = (fail_sum >= MAX_FAIL4) ? MAX_FAIL3 : fail_sum[2:0];
                end else if (any_good) begin
                    fail_next = 3'd0;
                end
                if (fail_next == MAX_FAIL3) begin
                    state_next    = ST_LOCKED;
                    lock_cnt_next = LOCK_LOAD;
                end
            end
            ST_LOCKED: begin
                if (lock_cnt == '0) begin
                    state_next = ST_OPEN;
                    fail_next  = 3'd0;
                end else begin
                    lock_cnt_next = lock_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next    = ST_OPEN;
                fail_next     = 3'd0;
                lock_cnt_next = '0;
            end
        endcase
    end

    // State, failure count and lock counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_OPEN;
            fail_count <= 3'd0;
            lock_cnt   <= '0;
        end else begin
            state      <= state_next;
            fail_count <= fail_next;
            lock_cnt   <= lock_cnt_next;
        end
    end

    // Storage and one-cycle read/error responses; the read samples the old word
    // when a write hits the same address in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            rd_err        <= 1'b0;
            wr_err        <= 1'b0;
        end else begin
            wr_err        <= wr_bad;
            rd_err        <= rd_bad || rd_blocked;
            rd_data_valid <= rd_good;
            if (rd_good) begin
                rd_data <= mem[rd_addr];
            end
            if (wr_good) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_secure_store.sv
// tb_secure_store: scoreboard bench for secure_store. The driver applies one
// cycle of stimulus, steps a behavioural model and queues the expected outputs;
// a monitor pops one entry after each rising edge and compares.
module tb_secure_store;

    localparam int          DEPTH       = 8;
    localparam int          ADDR_W      = 3;
    localparam logic [15:0] KEY         = 16'h0032;
    localparam int          MAX_FAIL    = 3;
    localparam int          LOCK_CYCLES = 16;

    logic              clk;
    logic              rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [15:0]       wr_key;
    logic              wr_err;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_key;
    logic              rd_data_valid;
    logic [31:0]       rd_data;
    logic              rd_err;
    logic              locked;
    logic [2:0]        fail_count;

    typedef struct {
        logic        wr_err;
        logic        rd_err;
        logic        rd_dv;
        logic [31:0] rd_data;
        logic        locked;
        logic        wr_ready;
        logic [2:0]  fail_count;
    } exp_t;

    exp_t        exp_q[$];

    logic [31:0] m_mem [DEPTH];
    int          m_fail;
    int          m_lock_left;
    logic [31:0] m_rd_data;

    int tests_run;
    int tests_failed;

    secure_store #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .KEY(KEY),
        .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_key(wr_key), .wr_err(wr_err),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_key(rd_key),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_err(rd_err),
        .locked(locked), .fail_count(fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle at the falling edge and queue what the store must show after the next rising edge.
    task automatic applyStimulus(input logic r, input logic wv, input logic [ADDR_W-1:0] wa,
                                 input logic [31:0] wd, input logic [15:0] wk,
                                 input logic rv, input logic [ADDR_W-1:0] ra, input logic [15:0] rk);
        exp_t e;
        int   fails;
        bit   good;
        @(negedge clk);
        rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd; wr_key = wk;
        rd_valid = rv; rd_addr = ra; rd_key = rk;
        e.wr_err = 1'b0; e.rd_err = 1'b0; e.rd_dv = 1'b0;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
            m_fail = 0; m_lock_left = 0; m_rd_data = 32'h0;
        end else if (m_lock_left > 0) begin
            e.rd_err = rv;
            m_lock_left--;
            if (m_lock_left == 0) m_fail = 0;
        end else begin
            e.wr_err = wv && (wk != KEY);
            e.rd_err = rv && (rk != KEY);
            e.rd_dv  = rv && (rk == KEY);
            if (e.rd_dv) m_rd_data = m_mem[ra];
            if (wv && (wk == KEY)) m_mem[wa] = wd;
            fails = int'(e.wr_err) + int'(e.rd_err);
            good  = (wv && (wk == KEY)) || e.rd_dv;
            if (fails > 0) m_fail = (m_fail + fails > MAX_FAIL) ? MAX_FAIL : m_fail + fails;
            else if (good) m_fail = 0;
            if (m_fail == MAX_FAIL) m_lock_left = LOCK_CYCLES;
        end
        e.rd_data    = m_rd_data;
        e.locked     = (m_lock_left > 0);
        e.wr_ready   = (m_lock_left == 0);
        e.fail_count = 3'(m_fail);
        exp_q.push_back(e);
    endtask

    // One named comparison against the scoreboard entry.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, 32'h0, KEY, 1'b0, '0, KEY);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, '0, 32'h0, KEY, 1'b0, '0, KEY);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [15:0] k);
        applyStimulus(1'b0, 1'b1, a, d, k, 1'b0, '0, KEY);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [15:0] k);
        applyStimulus(1'b0, 1'b0, '0, 32'h0, KEY, 1'b1, a, k);
    endtask

    // Monitor: compare every output after each rising edge that has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("wr_err",        32'(wr_err),        32'(e.wr_err));
                checkOutput("rd_err",        32'(rd_err),        32'(e.rd_err));
                checkOutput("rd_data_valid", 32'(rd_data_valid), 32'(e.rd_dv));
                checkOutput("rd_data",       rd_data,            e.rd_data);
                checkOutput("locked",        32'(locked),        32'(e.locked));
                checkOutput("wr_ready",      32'(wr_ready),      32'(e.wr_ready));
                checkOutput("fail_count",    32'(fail_count),    32'(e.fail_count));
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        tests_run = 0; tests_failed = 0;
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = 32'h0; wr_key = 16'h0;
        rd_valid = 1'b0; rd_addr = '0; rd_key = 16'h0;
        m_fail = 0; m_lock_left = 0; m_rd_data = 32'h0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

        doReset();
        doReset();
        idle();

        wr(3'd2, 32'h0000_0051, KEY);
        rd(3'd2, KEY);
        idle();

        wr(3'd5, 32'hDEAD_BEEF, 16'h0031);
        rd(3'd5, KEY);
        idle();

        rd(3'd0, 16'h1111);
        rd(3'd0, 16'h2222);
        rd(3'd0, 16'h3333);
        rd(3'd2, KEY);
        wr(3'd4, 32'h1234_5678, KEY);
        for (int i = 0; i < LOCK_CYCLES; i++) idle();
        wr(3'd3, 32'h0000_0077, KEY);
        rd(3'd3, KEY);
        rd(3'd4, KEY);

        wr(3'd1, 32'h0000_000A, KEY);
        applyStimulus(1'b0, 1'b1, 3'd1, 32'h0000_000B, KEY, 1'b1, 3'd1, KEY);
        rd(3'd1, KEY);

        rd(3'd0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 3'd6, 32'hFFFF_0000, 16'h00FF, 1'b1, 3'd6, 16'h00FE);
        for (int i = 0; i < LOCK_CYCLES + 1; i++) idle();

        rd(3'd0, 16'h0001);
        rd(3'd2, KEY);
        rd(3'd0, 16'h0002);
        rd(3'd0, 16'h0003);
        idle();
        wr(3'd7, 32'hCAFE_0007, KEY);

        rd(3'd0, 16'h0004);
        rd(3'd0, 16'h0005);
        rd(3'd0, 16'h0006);
        for (int i = 0; i < 4; i++) idle();
        applyStimulus(1'b1, 1'b0, '0, 32'h0, KEY, 1'b1, 3'd1, KEY);
        idle();
        for (int i = 0; i < DEPTH; i++) rd(ADDR_W'(i), KEY);

        for (int n = 0; n < 600; n++) begin
            logic r, wv, rv;
            logic [15:0] wk, rk;
            r  = ($urandom_range(0, 199) == 0);
            wv = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            wk = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : KEY;
            rk = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : KEY;
            applyStimulus(r, wv, ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom(), wk,
                          rv, ADDR_W'($urandom_range(0, DEPTH - 1)), rk);
        end

        idle();
        repeat (3) @(posedge clk);
        #2;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
